// File: rtl/riscboy_ppu_bus_scheduler.sv
// Shares the PPU's read port among N_REQ address generators: urgent-first / round-robin
// arbitration, credit-gated issue, registered address stage, steered responses.
// Optional stall statistics counter: define RISCBOY_PPU_SCHED_STATS_EN.
module riscboy_ppu_bus_scheduler #(
  parameter int N_REQ         = 4,
  parameter int W_ADDR        = 18,
  parameter int W_DATA        = 16,
  parameter int MAX_IN_FLIGHT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ppu_running,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ-1:0]        req_urgent,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ*W_ADDR-1:0] req_addr,
  output logic [N_REQ-1:0]        req_dph_vld,
  output logic [W_DATA-1:0]       req_dph_data,
  output logic [W_ADDR-1:0]       mem_addr,
  output logic                    mem_addr_vld,
  input  logic                    mem_addr_rdy,
  input  logic [W_DATA-1:0]       mem_rdata,
  input  logic                    mem_rdata_vld,
  output logic                    busy,
  output logic                    err_spurious,
  output logic [15:0]             stall_cycles
);

  localparam int IFW = $clog2(MAX_IN_FLIGHT + 1);
  localparam int PW  = (MAX_IN_FLIGHT > 1) ? $clog2(MAX_IN_FLIGHT) : 1;
  localparam int IW  = $clog2(N_REQ);
  localparam logic [IFW-1:0] MAX_IF   = IFW'(MAX_IN_FLIGHT);
  localparam logic [PW-1:0]  PTR_LAST = PW'(MAX_IN_FLIGHT - 1);

  // Handshakes are valid/ready: a beat transfers on a cycle where both are high;
  // valid is never made to depend on ready, and a pending valid holds until taken.

  logic [IFW-1:0]    in_flight_q, in_flight_d;
  logic [IFW-1:0]    buf_cnt_q, buf_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [N_REQ-1:0]  buf_q [MAX_IN_FLIGHT];
  logic [N_REQ-1:0]  rr_last_q;
  logic [N_REQ-1:0]  owner_q;
  logic [W_ADDR-1:0] mem_addr_q;
  logic              mem_addr_vld_q;
  logic              err_q;

  logic              stage_free;
  logic              issue;
  logic              hs;
  logic              push;
  logic              rsp_ok;
  logic [N_REQ-1:0]  urgent;
  logic [N_REQ-1:0]  grant;
  logic [IW-1:0]     last_idx;
  logic [IW:0]       rr_idx;
  logic              found;
  logic [W_ADDR-1:0] sel_addr;

  assign stage_free = !mem_addr_vld_q || mem_addr_rdy;
  assign issue      = ppu_running && (in_flight_q < MAX_IF) && stage_free;
  assign urgent     = req_vld & req_urgent;

  always_comb begin
    grant    = '0;
    last_idx = '0;
    rr_idx   = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_last_q[i]) last_idx = IW'(i);
    end
    if (issue) begin
      if (|urgent) begin
        // Descending scan so the lowest-index urgent requester is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (urgent[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
          end
        end
      end else begin
        for (int k = 1; k <= N_REQ; k++) begin
          rr_idx = {1'b0, last_idx} + (IW+1)'(k);
          if (rr_idx >= (IW+1)'(N_REQ)) rr_idx = rr_idx - (IW+1)'(N_REQ);
          if (!found && req_vld[rr_idx[IW-1:0]]) begin
            grant[rr_idx[IW-1:0]] = 1'b1;
            found                 = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_addr = sel_addr | req_addr[i*W_ADDR +: W_ADDR];
    end
  end

  assign hs     = |grant;
  assign push   = mem_addr_vld_q && mem_addr_rdy;
  assign rsp_ok = mem_rdata_vld && (buf_cnt_q != '0);

  always_comb begin
    in_flight_d = in_flight_q;
    buf_cnt_d   = buf_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    case ({hs, rsp_ok})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase
    case ({push, rsp_ok})
      2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
      2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
    if (push)   wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rsp_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q    <= '0;
      buf_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rr_last_q      <= {1'b1, {(N_REQ-1){1'b0}}};
      owner_q        <= '0;
      mem_addr_q     <= '0;
      mem_addr_vld_q <= 1'b0;
      err_q          <= 1'b0;
      for (int i = 0; i < MAX_IN_FLIGHT; i++) buf_q[i] <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      buf_cnt_q   <= buf_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (hs) begin
        mem_addr_q     <= sel_addr;
        mem_addr_vld_q <= 1'b1;
        owner_q        <= grant;
        rr_last_q      <= grant;
      end else if (stage_free) begin
        mem_addr_vld_q <= 1'b0;
      end
      if (push) buf_q[wr_ptr_q] <= owner_q;
      if (mem_rdata_vld && (buf_cnt_q == '0)) err_q <= 1'b1;
    end
  end

  assign req_rdy      = grant;
  assign req_dph_vld  = rsp_ok ? buf_q[rd_ptr_q] : '0;
  assign req_dph_data = mem_rdata;
  assign mem_addr     = mem_addr_q;
  assign mem_addr_vld = mem_addr_vld_q;
  assign busy         = (in_flight_q != '0);
  assign err_spurious = err_q;

`ifdef RISCBOY_PPU_SCHED_STATS_EN
  logic [15:0] stall_q;

  // Counts cycles where someone wants the bus while running but nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (|req_vld && ppu_running && (grant == '0) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_riscboy_ppu_bus_scheduler.sv
// Directed bench for riscboy_ppu_bus_scheduler: round-robin, urgent override, credit limit,
// backpressure, drain/spurious, stall statistics and mid-operation reset.
module tb_riscboy_ppu_bus_scheduler;

  localparam int N_REQ = 4;
  localparam int W_ADDR = 18;
  localparam int W_DATA = 16;
  localparam int MAX_IN_FLIGHT = 4;
`ifdef RISCBOY_PPU_SCHED_STATS_EN
  localparam logic [15:0] EXP_STALL = 16'd10;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    ppu_running;
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ-1:0]        req_urgent;
  logic [N_REQ-1:0]        req_rdy;
  logic [N_REQ*W_ADDR-1:0] req_addr;
  logic [N_REQ-1:0]        req_dph_vld;
  logic [W_DATA-1:0]       req_dph_data;
  logic [W_ADDR-1:0]       mem_addr;
  logic                    mem_addr_vld;
  logic                    mem_addr_rdy;
  logic [W_DATA-1:0]       mem_rdata;
  logic                    mem_rdata_vld;
  logic                    busy;
  logic                    err_spurious;
  logic [15:0]             stall_cycles;

  riscboy_ppu_bus_scheduler #(
    .N_REQ(N_REQ), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .MAX_IN_FLIGHT(MAX_IN_FLIGHT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ppu_running(ppu_running),
    .req_vld(req_vld), .req_urgent(req_urgent), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_dph_vld(req_dph_vld), .req_dph_data(req_dph_data),
    .mem_addr(mem_addr), .mem_addr_vld(mem_addr_vld), .mem_addr_rdy(mem_addr_rdy),
    .mem_rdata(mem_rdata), .mem_rdata_vld(mem_rdata_vld),
    .busy(busy), .err_spurious(err_spurious), .stall_cycles(stall_cycles)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: owners in issue order, plus a tiny model of the stage and credit count
  logic [N_REQ-1:0]  exp_q[$];
  logic              stg_vld;
  logic [W_ADDR-1:0] stg_addr;
  int                model_if;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W_ADDR-1:0] addr_of(input logic [3:0] g);
    case (g)
      4'b0001: addr_of = 18'h000A0;
      4'b0010: addr_of = 18'h000A2;
      4'b0100: addr_of = 18'h000A4;
      4'b1000: addr_of = 18'h000A6;
      default: addr_of = 18'h00000;
    endcase
  endfunction

  task automatic set_in(input logic run, input logic [3:0] vld, input logic [3:0] urg,
                        input logic ardy, input logic rvld, input logic [15:0] rdata);
    ppu_running   = run;
    req_vld       = vld;
    req_urgent    = urg;
    mem_addr_rdy  = ardy;
    mem_rdata_vld = rvld;
    mem_rdata     = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle with mem_addr_rdy high; checks grant, stage, credits and steering.
  task automatic stream_cycle(input logic run, input logic [3:0] vld, input logic [3:0] urg,
                              input logic [3:0] exp_g, input logic rvld, input logic [15:0] rdata);
    logic [3:0] e;
    set_in(run, vld, urg, 1'b1, rvld, rdata);
    @(negedge clk);
    check("grant", req_rdy, exp_g);
    check("busy", busy, model_if != 0);
    check("stage_vld", mem_addr_vld, stg_vld);
    if (stg_vld) check("stage_addr", mem_addr, stg_addr);
    if (rvld) begin
      e = 4'h0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("rsp_owner", req_dph_vld, e);
      if (e != 4'h0) begin
        check("rsp_data", req_dph_data, rdata);
        model_if--;
      end
    end
    if (exp_g != 4'h0) begin
      exp_q.push_back(exp_g);
      model_if++;
      stg_vld  = 1'b1;
      stg_addr = addr_of(exp_g);
    end else begin
      stg_vld = 1'b0;
    end
    next_cycle();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_addr_vld"}, mem_addr_vld, 0);
    check({tag, "_req_rdy"}, req_rdy, 0);
    check({tag, "_dph_vld"}, req_dph_vld, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_spurious, 0);
    check({tag, "_stall"}, stall_cycles, 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_if = 0;
    stg_vld  = 1'b0;
    stg_addr = '0;
  endtask

  initial begin
    logic [3:0] t2_grant [8];
    logic [3:0] t3_grant [9];

    for (int i = 0; i < N_REQ; i++) req_addr[i*W_ADDR +: W_ADDR] = 18'h000A0 + 18'(2 * i);
    set_in(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0);
    clear_model();
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Round-robin with responses two cycles after issue
    for (int c = 0; c < 10; c++) begin
      stream_cycle(1'b1, (c < 8) ? 4'b1111 : 4'b0000, 4'b0000,
                   (c < 8) ? 4'(1 << (c % 4)) : 4'b0000, c >= 2, 16'hD000 + 16'(c));
    end
    stream_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0);

    // Urgent override, then round-robin resumes after the urgent winner
    t2_grant = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    for (int c = 0; c < 8; c++) begin
      stream_cycle(1'b1, (c < 6) ? 4'b1111 : 4'b0000, (c < 4) ? 4'b0100 : 4'b0000,
                   t2_grant[c], c >= 2, 16'hB000 + 16'(c));
    end
    stream_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0);

    // Credit limit: four issues, stall, one response frees exactly one grant a cycle later
    t3_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int c = 0; c < 9; c++) begin
      stream_cycle(1'b1, 4'b1111, 4'b0000, t3_grant[c], c == 6, 16'hC006);
    end
    for (int c = 0; c < 4; c++) begin
      stream_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'hC100 + 16'(c));
    end
    stream_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0);

    // Backpressure on the address stage
    set_in(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("bp_grant", req_rdy, 4'b0100);
    next_cycle();
    exp_q.push_back(4'b0100);
    model_if = 1;
    for (int c = 0; c < 5; c++) begin
      set_in(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      check("bp_hold_vld", mem_addr_vld, 1);
      check("bp_hold_addr", mem_addr, 18'h000A4);
      check("bp_hold_rdy", req_rdy, 4'b0000);
      next_cycle();
    end
    set_in(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("bp_release_vld", mem_addr_vld, 1);
    check("bp_release_addr", mem_addr, 18'h000A4);
    next_cycle();
    @(negedge clk);
    check("bp_after_vld", mem_addr_vld, 0);
    next_cycle();
    stg_vld = 1'b0;
    stream_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h4444);
    stream_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0);

    // Drain with ppu_running low, then a spurious beat
    stream_cycle(1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b0, 16'h0);
    stream_cycle(1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 16'h0);
    stream_cycle(1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b0, 16'h0);
    stream_cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 16'h0);
    stream_cycle(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b1, 16'h1111);
    stream_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h2222);
    stream_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h3333);
    set_in(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h9999);
    @(negedge clk);
    check("drain_busy", busy, 0);
    check("spurious_dph", req_dph_vld, 4'b0000);
    check("spurious_pre", err_spurious, 0);
    next_cycle();
    set_in(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("spurious_set", err_spurious, 1);
    next_cycle();

    // Fresh reset, then stall statistics while credits are exhausted
    rst_n = 1'b0;
    clear_model();
    #2;
    check_reset_state("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 4; c++) stream_cycle(1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 16'h0);
    for (int c = 0; c < 10; c++) stream_cycle(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 16'h0);
    set_in(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("stall_cycles", stall_cycles, EXP_STALL);
    check("stall_busy", busy, 1);
    next_cycle();

    // Reset with four beats outstanding; a late response is spurious
    rst_n = 1'b0;
    clear_model();
    #2;
    check("midreset_busy", busy, 0);
    check("midreset_vld", mem_addr_vld, 0);
    check("midreset_stall", stall_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    set_in(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h5555);
    @(negedge clk);
    check("late_rsp_dph", req_dph_vld, 4'b0000);
    check("late_rsp_err_pre", err_spurious, 0);
    next_cycle();
    set_in(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    check("late_rsp_err", err_spurious, 1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscboy_ppu_bus_scheduler.md
Name: riscboy_ppu_bus_scheduler

Overview:
Shares the PPU's single read-only memory port among N_REQ address generators. Arbitration is round-robin, with an urgent-override class for scanout-critical requesters. Issue is gated by an in-flight credit counter, and the address goes out through a registered stage. A circular steering buffer returns each read response to the requester that issued it.

Parameters:
N_REQ, 4, number of requesters (2..16)
W_ADDR, 18, byte address width
W_DATA, 16, read data width
MAX_IN_FLIGHT, 4, maximum outstanding beats, counting the address stage plus awaiting data (1..8)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
ppu_running  in  1  low = no new grants; in-flight traffic drains
req_vld  in  N_REQ  per-requester address valid
req_urgent  in  N_REQ  per-requester urgent flag, qualified by req_vld
req_rdy  out  N_REQ  one-hot accept; handshake = req_vld & req_rdy
req_addr  in  N_REQ*W_ADDR  packed addresses, requester i at [i*W_ADDR +: W_ADDR]
req_dph_vld  out  N_REQ  one-hot response strobe
req_dph_data  out  W_DATA  response data, shared by all requesters
mem_addr  out  W_ADDR  registered address
mem_addr_vld  out  1  address valid
mem_addr_rdy  in  1  memory accepts address
mem_rdata  in  W_DATA  read data
mem_rdata_vld  in  1  read data valid; at most one beat per cycle, in issue order
busy  out  1  in_flight != 0
err_spurious  out  1  sticky: rdata_vld arrived with steering buffer empty
stall_cycles  out  16  see Optional Feature; tied 0 when the feature is disabled

Behaviour:
- Reset: mem_addr=0, mem_addr_vld=0, req_rdy=0, req_dph_vld=0, busy=0, err_spurious=0, stall_cycles=0. rr_last=one-hot bit N_REQ-1, so requester 0 wins first. in_flight=0. Steering buffer empty (rd_ptr=wr_ptr=0).
- Counter widths: in_flight uses $clog2(MAX_IN_FLIGHT+1) bits; buffer pointers use $clog2(MAX_IN_FLIGHT) bits, minimum 1, and wrap from MAX_IN_FLIGHT-1 to 0.
- Issue condition: ppu_running && in_flight < MAX_IN_FLIGHT && stage_free, where stage_free = !mem_addr_vld || mem_addr_rdy.
- Grant selection (combinational) while issue holds:
  - If any req_vld & req_urgent: grant the lowest-index urgent requester.
  - Otherwise round-robin: grant the first valid requester strictly after rr_last in index order, wrapping.
  - When issue is false, grant is all zero.
  - req_rdy = grant.
- On a handshake:
  - mem_addr <= selected address; mem_addr_vld <= 1; in_flight increments; the grant is pushed into the stage's owner register.
  - rr_last <= grant, for both urgent and normal grants.
- Address stage:
  - If stage_free and no grant: mem_addr_vld <= 0.
  - mem_addr and the owner register hold stable while mem_addr_vld && !mem_addr_rdy.
  - Back-to-back issue, one beat per clock, is supported when mem_addr_rdy stays high.
- On a mem_addr_vld && mem_addr_rdy handshake: the owner is written to steering buffer[wr_ptr] and wr_ptr increments.
- Response path: combinational, zero added latency.
  - If mem_rdata_vld and the buffer is non-empty: req_dph_vld = buffer[rd_ptr], req_dph_data = mem_rdata, rd_ptr increments, in_flight decrements.
  - If mem_rdata_vld and the buffer is empty: req_dph_vld = 0, err_spurious <= 1, counters unchanged.
- Simultaneous accept and response in one cycle: in_flight unchanged.
- Buffer capacity: it never overflows, because in_flight ≤ MAX_IN_FLIGHT bounds occupancy. At in_flight == MAX_IN_FLIGHT, req_rdy = 0.
- A response may retire a credit in the same cycle it frees space, but the freed credit is usable only the next cycle. The credit check uses the registered in_flight value.
- ppu_running falling: no new grants. A pending mem_addr_vld stays asserted until accepted. Outstanding responses are still steered. busy falls once in_flight reaches 0.
- Reset mid-operation: all state clears immediately. Responses returning after reset are treated as spurious.

Optional Feature:
RISCBOY_PPU_SCHED_STATS_EN
- Defined: stall_cycles is a 16-bit saturating counter. It increments every cycle where |req_vld && ppu_running && req_rdy == 0. It saturates at 0xFFFF and clears only on reset.
- Undefined: stall_cycles = 0 and no counter flops exist.

Test Plan:
1. Round-robin: req_vld=4'b1111, req_urgent=0, mem_addr_rdy=1, responses returned 2 cycles after issue -> grants 0,1,2,3,0,...; mem_addr_vld high continuously; each req_dph_vld one-hot matches the issue order.
2. Urgent override: req_vld=4'b1111, req_urgent=4'b0100 -> requester 2 granted every cycle. Drop urgent -> next grant is requester 3.
3. Credit limit: MAX_IN_FLIGHT=4, mem_addr_rdy=1, no responses -> exactly 4 handshakes, then req_rdy=0 and busy=1. One mem_rdata_vld -> exactly one further grant, in the following cycle.
4. Backpressure: mem_addr_rdy=0 for 5 cycles with address 0x00A4 pending -> mem_addr holds 0x00A4, req_rdy=0. Release -> 0x00A4 accepted, owner pushed once.
5. Drain: after 3 issues deassert ppu_running, return 3 responses with data 0x1111, 0x2222, 0x3333 -> steered to the correct owners in order; busy falls the cycle after the last one; a fourth rdata_vld sets err_spurious.
6. Stats (macro defined): req_vld=1 held, ppu_running=1, credits exhausted for 10 cycles -> stall_cycles=10. Macro undefined -> stall_cycles stays 0.
